// File: rtl/alsu_mst_pkg.sv
// alsu_mst_pkg: shared command type, FSM states, opcodes and ALSU idle pin pattern
package alsu_mst_pkg;
    typedef struct packed {
        logic [2:0]        opcode;
        logic signed [2:0] a;
        logic signed [2:0] b;
        logic              cin;
        logic              red_a;
        logic              red_b;
        logic              byp_a;
        logic              byp_b;
        logic              dir;
        logic              serial;
    } alsu_cmd_t;

    typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RESP} state_t;

    localparam logic [2:0] OP_OR     = 3'd0;
    localparam logic [2:0] OP_XOR    = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_MUL    = 3'd3;
    localparam logic [2:0] OP_SHIFT  = 3'd4;
    localparam logic [2:0] OP_ROTATE = 3'd5;

    // All-zero pins make the ALSU compute OR of zeros: out 0, leds 0
    localparam alsu_cmd_t IDLE_CMD = '0;
endpackage

// File: rtl/alsu_cmd_master_if.sv
// alsu_cmd_master_if: command and response handshakes between a client and the ALSU command master
interface alsu_cmd_master_if;
    import alsu_mst_pkg::*;
    logic              cmd_valid;
    logic              cmd_ready;
    alsu_cmd_t         cmd;
    logic              rsp_valid;
    logic              rsp_ready;
    logic signed [5:0] rsp_out;
    logic              rsp_invalid;
    logic [2:0]        rsp_opcode;
    modport master (
        output cmd_valid, cmd, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_out, rsp_invalid, rsp_opcode
    );
    modport slave (
        input  cmd_valid, cmd, rsp_ready,
        output cmd_ready, rsp_valid, rsp_out, rsp_invalid, rsp_opcode
    );
endinterface

// File: rtl/alsu.sv
// alsu: registered-input 3-bit arithmetic/logic/shift unit with invalid-op led blink (two-cycle latency)
module alsu #(
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [2:0] a,
    input  logic signed [2:0] b,
    input  logic [2:0]        opcode,
    input  logic              cin,
    input  logic              serial_in,
    input  logic              red_op_a,
    input  logic              red_op_b,
    input  logic              bypass_a,
    input  logic              bypass_b,
    input  logic              direction,
    output logic signed [5:0] out,
    output logic [15:0]       leds
);
    logic signed [2:0] a_r, b_r;
    logic [2:0]        opcode_r;
    logic              cin_r, serial_r, red_a_r, red_b_r, byp_a_r, byp_b_r, dir_r;
    logic signed [5:0] ax, bx;
    logic              invalid, add_cin;

    assign ax      = {{3{a_r[2]}}, a_r};
    assign bx      = {{3{b_r[2]}}, b_r};
    assign add_cin = (FULL_ADDER == "ON") ? cin_r : 1'b0;
    assign invalid = (opcode_r[2] & opcode_r[1]) | ((red_a_r | red_b_r) & (opcode_r[2] | opcode_r[1]));

    // Input sample stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {a_r, b_r, opcode_r} <= '0;
            {cin_r, serial_r, red_a_r, red_b_r, byp_a_r, byp_b_r, dir_r} <= '0;
        end else begin
            {a_r, b_r, opcode_r} <= {a, b, opcode};
            {cin_r, serial_r, red_a_r, red_b_r, byp_a_r, byp_b_r, dir_r} <=
                {cin, serial_in, red_op_a, red_op_b, bypass_a, bypass_b, direction};
        end
    end

    // Result stage: bypass beats invalid, invalid blinks leds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out  <= '0;
            leds <= '0;
        end else if (byp_a_r || byp_b_r) begin
            out  <= (byp_a_r && (!byp_b_r || INPUT_PRIORITY == "A")) ? ax : bx;
            leds <= '0;
        end else if (invalid) begin
            out  <= '0;
            leds <= ~leds;
        end else begin
            leds <= '0;
            case (opcode_r)
                3'd0:    out <= red_a_r ? {5'd0, |a_r} : red_b_r ? {5'd0, |b_r} : ax | bx;
                3'd1:    out <= red_a_r ? {5'd0, ^a_r} : red_b_r ? {5'd0, ^b_r} : ax ^ bx;
                3'd2:    out <= ax + bx + {5'd0, add_cin};
                3'd3:    out <= ax * bx;
                3'd4:    out <= dir_r ? {out[4:0], serial_r} : {serial_r, out[5:1]};
                3'd5:    out <= dir_r ? {out[4:0], out[5]} : {out[0], out[5:1]};
                default: out <= '0;
            endcase
        end
    end
endmodule

// File: rtl/alsu_cmd_fifo.sv
// alsu_cmd_fifo: first-word-fall-through command queue, power-of-2 depth, wrapping pointers
module alsu_cmd_fifo
    import alsu_mst_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  alsu_cmd_t din,
    output logic      full,
    input  logic      pop,
    output alsu_cmd_t dout,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);

    alsu_cmd_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    // full is the pre-pop state, so a full queue refuses a push even while popping
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/alsu_cmd_master.sv
// alsu_cmd_master: queues commands, drives them one at a time onto ALSU pins and returns captured results.
// Define ALSU_MST_STATS_EN to add saturating stat_cmds / stat_invalid delivery counters.
module alsu_cmd_master
    import alsu_mst_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int ALSU_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    alsu_cmd_master_if.slave  bus,
    output logic signed [2:0] alsu_A,
    output logic signed [2:0] alsu_B,
    output logic [2:0]        alsu_opcode,
    output logic              alsu_cin,
    output logic              alsu_red_op_A,
    output logic              alsu_red_op_B,
    output logic              alsu_bypass_A,
    output logic              alsu_bypass_B,
    output logic              alsu_direction,
    output logic              alsu_serial_in,
    input  logic signed [5:0] alsu_out,
    input  logic [15:0]       alsu_leds
`ifdef ALSU_MST_STATS_EN
    ,
    output logic [15:0]       stat_cmds,
    output logic [15:0]       stat_invalid
`endif
);
    localparam int CW = $clog2(ALSU_LATENCY + 1);

    state_t        state;
    alsu_cmd_t     cur, pins, head;
    logic [CW-1:0] wait_cnt;
    logic          full, empty, pop;

    assign bus.cmd_ready = !full;
    assign pop           = (state == IDLE) && !empty;

    alsu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.cmd_valid),
        .din   (bus.cmd),
        .full  (full),
        .pop   (pop),
        .dout  (head),
        .empty (empty)
    );

    assign alsu_A         = pins.a;
    assign alsu_B         = pins.b;
    assign alsu_opcode    = pins.opcode;
    assign alsu_cin       = pins.cin;
    assign alsu_red_op_A  = pins.red_a;
    assign alsu_red_op_B  = pins.red_b;
    assign alsu_bypass_A  = pins.byp_a;
    assign alsu_bypass_B  = pins.byp_b;
    assign alsu_direction = pins.dir;
    assign alsu_serial_in = pins.serial;

    // Sequencer: pins carry the command for the single DRIVE cycle only, result captured after the latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cur             <= IDLE_CMD;
            pins            <= IDLE_CMD;
            wait_cnt        <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_out     <= '0;
            bus.rsp_invalid <= 1'b0;
            bus.rsp_opcode  <= '0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    cur   <= head;
                    pins  <= head;
                    state <= DRIVE;
                end
                DRIVE: begin
                    pins     <= IDLE_CMD;
                    wait_cnt <= CW'(ALSU_LATENCY - 1);
                    state    <= WAIT;
                end
                WAIT: if (wait_cnt == '0) begin
                    bus.rsp_out     <= alsu_out;
                    bus.rsp_invalid <= |alsu_leds;
                    bus.rsp_opcode  <= cur.opcode;
                    bus.rsp_valid   <= 1'b1;
                    state           <= RESP;
                end else begin
                    wait_cnt <= wait_cnt - CW'(1);
                end
                RESP: if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALSU_MST_STATS_EN
    // Delivered-response counters, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cmds    <= '0;
            stat_invalid <= '0;
        end else if (bus.rsp_valid && bus.rsp_ready) begin
            if (stat_cmds != '1) stat_cmds <= stat_cmds + 16'd1;
            if (bus.rsp_invalid && stat_invalid != '1) stat_invalid <= stat_invalid + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alsu_cmd_master.sv
// tb_alsu_cmd_master: random and directed commands through the master into a real ALSU, checked against a queue model
module tb_alsu_cmd_master;
    import alsu_mst_pkg::*;

    typedef struct packed {
        logic [5:0] out;
        logic       inv;
        logic [2:0] op;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [2:0] alsu_A, alsu_B;
    logic [2:0]        alsu_opcode;
    logic              alsu_cin, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
    logic              alsu_direction, alsu_serial_in;
    logic signed [5:0] alsu_out;
    logic [15:0]       alsu_leds;
`ifdef ALSU_MST_STATS_EN
    logic [15:0]       stat_cmds, stat_invalid;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_rsp = 0;
    int   n_inv = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    alsu_cmd_master_if bus();

    always #5 clk = ~clk;

    alsu_cmd_master #(.FIFO_DEPTH(4), .ALSU_LATENCY(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave),
        .alsu_A         (alsu_A),
        .alsu_B         (alsu_B),
        .alsu_opcode    (alsu_opcode),
        .alsu_cin       (alsu_cin),
        .alsu_red_op_A  (alsu_red_op_A),
        .alsu_red_op_B  (alsu_red_op_B),
        .alsu_bypass_A  (alsu_bypass_A),
        .alsu_bypass_B  (alsu_bypass_B),
        .alsu_direction (alsu_direction),
        .alsu_serial_in (alsu_serial_in),
        .alsu_out       (alsu_out),
        .alsu_leds      (alsu_leds)
`ifdef ALSU_MST_STATS_EN
        ,
        .stat_cmds      (stat_cmds),
        .stat_invalid   (stat_invalid)
`endif
    );

    alsu #(.INPUT_PRIORITY("A"), .FULL_ADDER("ON")) u_alsu (
        .clk       (clk),
        .rst       (rst),
        .a         (alsu_A),
        .b         (alsu_B),
        .opcode    (alsu_opcode),
        .cin       (alsu_cin),
        .serial_in (alsu_serial_in),
        .red_op_a  (alsu_red_op_A),
        .red_op_b  (alsu_red_op_B),
        .bypass_a  (alsu_bypass_A),
        .bypass_b  (alsu_bypass_B),
        .direction (alsu_direction),
        .out       (alsu_out),
        .leds      (alsu_leds)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected response from the ALSU rules; the ALSU result register is always 0 before a command
    function automatic exp_t model(input alsu_cmd_t c);
        int   av, bv, r;
        logic inv;
        av  = {{29{c.a[2]}}, c.a};
        bv  = {{29{c.b[2]}}, c.b};
        inv = 1'b0;
        r   = 0;
        if (c.byp_a) r = av;
        else if (c.byp_b) r = bv;
        else if (c.opcode > 3'd5 || ((c.red_a || c.red_b) && c.opcode > 3'd1)) inv = 1'b1;
        else if (c.opcode == OP_OR) r = c.red_a ? int'(|c.a) : c.red_b ? int'(|c.b) : (av | bv);
        else if (c.opcode == OP_XOR) r = c.red_a ? int'(^c.a) : c.red_b ? int'(^c.b) : (av ^ bv);
        else if (c.opcode == OP_ADD) r = av + bv + int'(c.cin);
        else if (c.opcode == OP_MUL) r = av * bv;
        else if (c.opcode == OP_SHIFT) r = c.serial ? (c.dir ? 1 : 32) : 0;
        return '{out: r[5:0], inv: inv, op: c.opcode};
    endfunction

    function automatic alsu_cmd_t mk(input logic [2:0] op, input int a, input int b, input logic cin, input logic byp_a);
        alsu_cmd_t c;
        c        = IDLE_CMD;
        c.opcode = op;
        c.a      = 3'(a);
        c.b      = 3'(b);
        c.cin    = cin;
        c.byp_a  = byp_a;
        return c;
    endfunction

    function automatic alsu_cmd_t rand_cmd();
        alsu_cmd_t c;
        c       = alsu_cmd_t'(16'($urandom()));
        c.byp_a = ($urandom_range(0, 7) == 0);
        c.byp_b = ($urandom_range(0, 7) == 0);
        c.red_a = ($urandom_range(0, 3) == 0);
        c.red_b = ($urandom_range(0, 3) == 0);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input alsu_cmd_t c, input int budget, output logic ok);
        int   n;
        logic r;
        n             = 0;
        bus.cmd       = c;
        bus.cmd_valid = 1'b1;
        do begin
            r = bus.cmd_ready;
            tick();
            n++;
        end while (!r && n < budget);
        if (r) exp_q.push_back(model(c));
        ok            = r;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_one(input string tag, input alsu_cmd_t c, input logic [5:0] eo, input logic ei);
        logic ok;
        int   n;
        send(c, 5, ok);
        check({tag, "_accept"}, ok, 1);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_out"}, $unsigned(bus.rsp_out), eo);
        check({tag, "_invalid"}, bus.rsp_invalid, ei);
        check({tag, "_opcode"}, bus.rsp_opcode, c.opcode);
        tick();
        tick();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    // Response scoreboard: every delivered response must match the oldest accepted command
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            check("rsp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("rsp_out", $unsigned(bus.rsp_out), mon_e.out);
                check("rsp_invalid", bus.rsp_invalid, mon_e.inv);
                check("rsp_opcode", bus.rsp_opcode, mon_e.op);
                n_rsp++;
                n_inv += int'(mon_e.inv);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic ok, seen, done;
        bus.cmd_valid = 1'b0;
        bus.cmd       = IDLE_CMD;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_fields", {$unsigned(bus.rsp_out), bus.rsp_invalid, bus.rsp_opcode}, 0);
        check("rst_pins", {alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_red_op_A, alsu_red_op_B,
                           alsu_bypass_A, alsu_bypass_B, alsu_direction, alsu_serial_in}, 0);
        tick();

        run_one("add", mk(OP_ADD, 3, 2, 1'b1, 1'b0), 6'd6, 1'b0);
        run_one("mul", mk(OP_MUL, -2, 3, 1'b0, 1'b0), 6'b111010, 1'b0);
        run_one("op6", mk(3'd6, 1, 1, 1'b0, 1'b0), 6'd0, 1'b1);
        run_one("op6_byp", mk(3'd6, -1, 2, 1'b0, 1'b1), 6'b111111, 1'b0);

        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(rand_cmd(), 3, ok);
            check("bp_push", ok, 1);
        end
        send(rand_cmd(), 4, ok);
        check("bp_sixth_blocked", ok, 0);
        check("bp_cmd_ready", bus.cmd_ready, 0);
        bus.rsp_ready = 1'b1;
        send(rand_cmd(), 50, ok);
        check("bp_sixth_accepted", ok, 1);
        drain("bp_drain");
        tick();

        for (int i = 0; i < 3; i++) send(rand_cmd(), 5, ok);
        rst = 1'b1;
        exp_q.delete();
        n_rsp = 0;
        n_inv = 0;
        tick();
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen |= bus.rsp_valid;
        end
        check("midrst_no_rsp", seen, 0);
        check("midrst_cmd_ready", bus.cmd_ready, 1);
        run_one("post_rst", mk(OP_ADD, -4, 1, 1'b1, 1'b0), 6'b111110, 1'b0);

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    send(rand_cmd(), 200, ok);
                    check("rnd_accept", ok, 1);
                    repeat ($urandom_range(0, 2)) tick();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick();
                    bus.rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.rsp_ready = 1'b1;
        drain("rnd_drain");

`ifdef ALSU_MST_STATS_EN
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        run_one("st_add", mk(OP_ADD, 1, 1, 1'b0, 1'b0), 6'd2, 1'b0);
        run_one("st_or", mk(OP_OR, 1, 2, 1'b0, 1'b0), 6'd3, 1'b0);
        run_one("st_inv6", mk(3'd6, 0, 0, 1'b0, 1'b0), 6'd0, 1'b1);
        run_one("st_mul", mk(OP_MUL, 2, 2, 1'b0, 1'b0), 6'd4, 1'b0);
        run_one("st_inv7", mk(3'd7, 0, 0, 1'b0, 1'b0), 6'd0, 1'b1);
        check("stat_cmds", stat_cmds, 5);
        check("stat_invalid", stat_invalid, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
